// File: rtl/matrix_commutator_if.sv
// Signal bundle between the SVM pattern/decoder stage (master) and the commutation engine (slave).
// sel is a level request per output slice: a one-hot slice that differs from the current input starts a
// sequence when the phase is idle (OFF/ON), ce=1 and fault=0; otherwise it is simply not taken yet.
interface matrix_commutator_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 3
);
   logic                      ce;
   logic [N_OUT*N_IN-1:0]     sel;
   logic [N_OUT-1:0]          dir;
   logic                      fault_in;
   logic                      fault_clr;
   logic [N_OUT*2*N_IN-1:0]   gate;
   logic [N_OUT-1:0]          busy;
   logic                      fault;
   logic [N_OUT*3-1:0]        state_dbg;

   modport master (
      output ce, sel, dir, fault_in, fault_clr,
      input  gate, busy, fault, state_dbg
   );

   modport slave (
      input  ce, sel, dir, fault_in, fault_clr,
      output gate, busy, fault, state_dbg
   );
endinterface

// File: rtl/matrix_commutator.sv
// Four-step current-direction commutation engine for an N_IN x N_OUT matrix converter,
// one independent FSM per output phase, programmable step dwell and a clearable fault latch.
module matrix_commutator #(
   parameter int N_IN        = 3,
   parameter int N_OUT       = 3,
   parameter int STEP_CYCLES = 200
) (
   input logic                clk,
   input logic                rst_n,
   matrix_commutator_if.slave bus
);
   localparam int CNT_W = $clog2(STEP_CYCLES + 1);
   localparam int GW    = 2 * N_IN;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [N_IN-1:0]  IN_ONE   = N_IN'(1);

   typedef enum logic [2:0] {
      ST_OFF = 3'd0,
      ST_ON  = 3'd1,
      ST_S1  = 3'd2,
      ST_S2  = 3'd3,
      ST_S3  = 3'd4,
      ST_S4  = 3'd5
   } state_e;

   state_e              state_q [N_OUT];
   state_e              state_d [N_OUT];
   logic [N_IN-1:0]     cur_q   [N_OUT];
   logic [N_IN-1:0]     cur_d   [N_OUT];
   logic [N_IN-1:0]     tgt_q   [N_OUT];
   logic [N_IN-1:0]     tgt_d   [N_OUT];
   logic [CNT_W-1:0]    cnt_q   [N_OUT];
   logic [CNT_W-1:0]    cnt_d   [N_OUT];
   logic [N_OUT-1:0]    d_q, d_d;
   logic [N_OUT*GW-1:0] gate_q, gate_d;
   logic [N_OUT-1:0]    busy_q, busy_d;
   logic                fault_q, fault_d;
   logic [N_IN-1:0]     sl;

   // Conducting switch of each selected input: forward for positive current, reverse otherwise.
   function automatic logic [GW-1:0] cd_gates(input logic [N_IN-1:0] x, input logic fwd);
      logic [GW-1:0] g;
      g = '0;
      for (int k = 0; k < N_IN; k++) begin
         g[2*k]   = x[k] & fwd;
         g[2*k+1] = x[k] & ~fwd;
      end
      return g;
   endfunction

   function automatic logic [GW-1:0] both_gates(input logic [N_IN-1:0] x);
      logic [GW-1:0] g;
      g = '0;
      for (int k = 0; k < N_IN; k++) begin
         g[2*k]   = x[k];
         g[2*k+1] = x[k];
      end
      return g;
   endfunction

   function automatic logic is_onehot(input logic [N_IN-1:0] x);
      return (x != '0) && ((x & (x - IN_ONE)) == '0);
   endfunction

   always_comb begin
      fault_d = fault_q;
      if (bus.fault_in)
         fault_d = 1'b1;
      else if (bus.fault_clr)
         fault_d = 1'b0;

      sl     = '0;
      d_d    = d_q;
      gate_d = '0;
      busy_d = '0;
      for (int p = 0; p < N_OUT; p++) begin
         sl         = bus.sel[p*N_IN +: N_IN];
         state_d[p] = state_q[p];
         cur_d[p]   = cur_q[p];
         tgt_d[p]   = tgt_q[p];
         cnt_d[p]   = cnt_q[p];

         // Fault release drops cur so the restart always takes the OFF->S4 path.
         if (bus.fault_in) begin
            state_d[p] = ST_OFF;
            cur_d[p]   = '0;
            cnt_d[p]   = '0;
         end else if (bus.ce) begin
            case (state_q[p])
               ST_OFF, ST_ON: begin
                  if (!fault_q && is_onehot(sl) && (sl != cur_q[p])) begin
                     tgt_d[p]   = sl;
                     d_d[p]     = bus.dir[p];
                     cnt_d[p]   = '0;
                     state_d[p] = (state_q[p] == ST_ON) ? ST_S1 : ST_S4;
                  end
               end
               default: begin
                  if (cnt_q[p] == CNT_LAST) begin
                     cnt_d[p] = '0;
                     case (state_q[p])
                        ST_S1:   state_d[p] = ST_S2;
                        ST_S2:   state_d[p] = ST_S3;
                        ST_S3:   state_d[p] = ST_S4;
                        default: begin
                           state_d[p] = ST_ON;
                           cur_d[p]   = tgt_q[p];
                        end
                     endcase
                  end else begin
                     cnt_d[p] = cnt_q[p] + CNT_ONE;
                  end
               end
            endcase
         end

         case (state_d[p])
            ST_ON:   gate_d[p*GW +: GW] = both_gates(cur_d[p]);
            ST_S1:   gate_d[p*GW +: GW] = cd_gates(cur_d[p], d_d[p]);
            ST_S2:   gate_d[p*GW +: GW] = cd_gates(cur_d[p], d_d[p]) | cd_gates(tgt_d[p], d_d[p]);
            ST_S3:   gate_d[p*GW +: GW] = cd_gates(tgt_d[p], d_d[p]);
            ST_S4:   gate_d[p*GW +: GW] = both_gates(tgt_d[p]);
            default: gate_d[p*GW +: GW] = '0;
         endcase
         busy_d[p] = (state_d[p] != ST_OFF) && (state_d[p] != ST_ON);
      end

      if (fault_d)
         gate_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < N_OUT; p++) begin
            state_q[p] <= ST_OFF;
            cur_q[p]   <= '0;
            tgt_q[p]   <= '0;
            cnt_q[p]   <= '0;
         end
         d_q     <= '0;
         gate_q  <= '0;
         busy_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         for (int p = 0; p < N_OUT; p++) begin
            state_q[p] <= state_d[p];
            cur_q[p]   <= cur_d[p];
            tgt_q[p]   <= tgt_d[p];
            cnt_q[p]   <= cnt_d[p];
         end
         d_q     <= d_d;
         gate_q  <= gate_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   for (genvar p = 0; p < N_OUT; p++) begin : g_dbg
      assign bus.state_dbg[p*3 +: 3] = state_q[p];
   end

   assign bus.gate  = gate_q;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;
endmodule

// File: tb/tb_matrix_commutator.sv
// Directed bench for matrix_commutator (N_IN=3, N_OUT=3, STEP_CYCLES=4): per-cycle expected
// outputs are queued by the driver and compared by an independent negedge monitor.
module tb_matrix_commutator;
   logic clk;
   logic rst_n;

   matrix_commutator_if #(.N_IN(3), .N_OUT(3)) bus ();

   matrix_commutator #(.N_IN(3), .N_OUT(3), .STEP_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard state: {fault, busy[2:0], gate[17:0]}
   logic [21:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;

   // hand-set expectations for the current cycle
   logic [5:0] g0, g1, g2;
   logic [2:0] eb;
   logic       ef;
   string      tag;

   logic [21:0] mon_exp, mon_act;
   string       mon_tag;

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) begin
         exp_q.push_back({ef, eb, g2, g1, g0});
         tag_q.push_back(tag);
         @(negedge clk);
      end
   endtask

   task automatic set_sel(input int p, input logic [2:0] v);
      bus.sel[p*3 +: 3] = v;
   endtask

   // monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_act = {bus.fault, bus.busy, bus.gate};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL %s: got fault=%b busy=%b gate=%b_%b_%b, expected fault=%b busy=%b gate=%b_%b_%b",
                     mon_tag, mon_act[21], mon_act[20:18], mon_act[17:12], mon_act[11:6], mon_act[5:0],
                     mon_exp[21], mon_exp[20:18], mon_exp[17:12], mon_exp[11:6], mon_exp[5:0]);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.ce        = 1'b0;
      bus.sel       = '0;
      bus.dir       = '0;
      bus.fault_in  = 1'b0;
      bus.fault_clr = 1'b0;
      g0 = '0; g1 = '0; g2 = '0; eb = '0; ef = 1'b0;

      tag = "reset";
      cyc(2);
      rst_n  = 1'b1;
      bus.ce = 1'b1;

      // OFF -> S4 -> ON on input 0
      tag = "off_to_in0";
      set_sel(0, 3'b001); bus.dir[0] = 1'b1;
      g0 = 6'b000011; eb = 3'b001; cyc(4);
      eb = 3'b000; cyc(2);

      // in0 -> in1, positive current
      tag = "in0_in1_pos";
      set_sel(0, 3'b010); bus.dir[0] = 1'b1;
      eb = 3'b001;
      g0 = 6'b000001; cyc(4);
      g0 = 6'b000101; cyc(4);
      g0 = 6'b000100; cyc(4);
      g0 = 6'b001100; cyc(4);
      eb = 3'b000; cyc(2);

      // in1 -> in0, negative current, dir toggled mid-sequence
      tag = "in1_in0_neg";
      set_sel(0, 3'b001); bus.dir[0] = 1'b0;
      eb = 3'b001;
      g0 = 6'b001000; cyc(4);
      g0 = 6'b001010; cyc(2);
      bus.dir[0] = 1'b1; cyc(2);
      g0 = 6'b000010; cyc(4);
      g0 = 6'b000011; cyc(4);
      eb = 3'b000; cyc(2);

      // in0 -> in1, negative current; a new sel during busy is taken right after completion
      tag = "in0_in1_neg";
      set_sel(0, 3'b010); bus.dir[0] = 1'b0;
      eb = 3'b001;
      g0 = 6'b000010; cyc(4);
      g0 = 6'b001010; cyc(4);
      g0 = 6'b001000; cyc(2);
      set_sel(0, 3'b100); bus.dir[0] = 1'b1; cyc(2);
      g0 = 6'b001100; cyc(4);
      tag = "pending_sel";
      eb = 3'b000; cyc(1);
      eb = 3'b001;
      g0 = 6'b000100; cyc(4);
      g0 = 6'b010100; cyc(4);
      g0 = 6'b010000; cyc(4);
      g0 = 6'b110000; cyc(4);
      eb = 3'b000; cyc(2);

      // invalid and no-op requests while ON
      tag = "multi_hot";
      set_sel(0, 3'b011); cyc(3);
      tag = "zero_sel";
      set_sel(0, 3'b000); cyc(3);
      tag = "same_sel";
      set_sel(0, 3'b100); cyc(2);

      // fault during S2, clear handling
      tag = "pre_fault";
      set_sel(0, 3'b001); bus.dir[0] = 1'b1;
      eb = 3'b001;
      g0 = 6'b010000; cyc(4);
      g0 = 6'b010001; cyc(2);
      tag = "fault_s2";
      bus.fault_in = 1'b1;
      g0 = '0; eb = 3'b000; ef = 1'b1; cyc(1);
      tag = "fault_latched";
      bus.fault_in = 1'b0; cyc(2);
      tag = "clr_blocked";
      bus.fault_in = 1'b1; bus.fault_clr = 1'b1; cyc(1);
      bus.fault_in = 1'b0; bus.fault_clr = 1'b0; set_sel(0, 3'b000); cyc(1);
      tag = "fault_clr";
      bus.fault_clr = 1'b1;
      ef = 1'b0; cyc(1);
      tag = "off_after_clr";
      bus.fault_clr = 1'b0; cyc(2);
      tag = "restart_s4";
      set_sel(0, 3'b100); bus.dir[0] = 1'b1;
      g0 = 6'b110000; eb = 3'b001; cyc(4);
      eb = 3'b000; cyc(2);

      // ce pause during phase 0 S3 while phases 1 and 2 start up
      tag = "ce_pre";
      set_sel(0, 3'b001); bus.dir[0] = 1'b1;
      eb = 3'b001;
      g0 = 6'b010000; cyc(4);
      g0 = 6'b010001; cyc(4);
      tag = "ce_s3";
      set_sel(1, 3'b010); bus.dir[1] = 1'b0;
      set_sel(2, 3'b001); bus.dir[2] = 1'b1;
      g0 = 6'b000001; g1 = 6'b001100; g2 = 6'b000011; eb = 3'b111; cyc(2);
      tag = "ce_hold";
      bus.ce = 1'b0; cyc(10);
      tag = "ce_resume";
      bus.ce = 1'b1; cyc(2);
      g0 = 6'b000011; eb = 3'b001; cyc(4);
      eb = 3'b000; cyc(2);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
